// File: rtl/wb_regfile.sv
// wb_regfile: write-back select, 32x32 register file with write-through bypass, retired-instruction counter
//   clk, rst_n                  clock, asynchronous active-low reset
//   wb_valid                    MEM/WB holds a real instruction
//   ReadData, ALU_Result        write-back candidates
//   Write_Destination           destination register index
//   RegWrite, MemtoReg          write-back control
//   rs1_addr/rs2_addr           ID read addresses
//   rs1_data/rs2_data           combinational read data (bypassed)
//   wb_data, wb_we              selected write-back value and qualified enable
//   retire_count                retired-instruction counter
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [DATA_W-1:0] ReadData,
  input  logic [DATA_W-1:0] ALU_Result,
  input  logic [4:0]        Write_Destination,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we,
  output logic [CNT_W-1:0]  retire_count
);
  localparam logic [5:0] NR = 6'(NREG);
  logic [DATA_W-1:0] regs [NREG];
  logic [CNT_W-1:0]  cnt_q;
  logic              dst_ok;
  assign wb_data      = MemtoReg ? ReadData : ALU_Result;
  assign wb_we        = wb_valid & RegWrite & (Write_Destination != 5'd0);
  assign dst_ok       = {1'b0, Write_Destination} < NR;
  assign retire_count = cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      cnt_q <= '0;
    end else begin
      if (wb_we && dst_ok) regs[Write_Destination] <= wb_data;
      if (wb_valid) cnt_q <= cnt_q + CNT_W'(1);
    end
  end
  // r0 and unimplemented indices read 0 and never bypass; reset forces 0 so a
  // pending write-back cannot leak through the bypass while regs are held clear.
  function automatic logic [DATA_W-1:0] rd(input logic [4:0] a);
    return (!rst_n || a == 5'd0 || {1'b0, a} >= NR) ? '0 :
           (wb_we && a == Write_Destination) ? wb_data : regs[a];
  endfunction
  always_comb begin
    rs1_data = rd(rs1_addr);
    rs2_data = rd(rs2_addr);
  end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed self-checking bench for wb_regfile
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [31:0] ReadData;
  logic [31:0] ALU_Result;
  logic [4:0]  Write_Destination;
  logic        RegWrite;
  logic        MemtoReg;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] wb_data;
  logic        wb_we;
  logic [31:0] retire_count;
  int          total = 0;
  int          bad = 0;
  wb_regfile dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .ReadData(ReadData),
    .ALU_Result(ALU_Result), .Write_Destination(Write_Destination),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_data(wb_data), .wb_we(wb_we), .retire_count(retire_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [4:0] d,
                       input logic [31:0] alu, input logic [31:0] rdat);
    wb_valid = v;
    RegWrite = rw;
    MemtoReg = m2r;
    Write_Destination = d;
    ALU_Result = alu;
    ReadData = rdat;
  endtask
  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    #12;
    chk("rst_cnt", retire_count, 32'h0);
    chk("rst_rd", rs1_data, 32'h0);
    rst_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 1'b1, 1'b0, 5'(i), 32'h1000_0000 | 32'(i), 32'h0);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    rs1_addr = 5'd31;
    rs2_addr = 5'd1;
    #1;
    chk("load_r31", rs1_data, 32'h1000_001F);
    chk("load_r1", rs2_data, 32'h1000_0001);
    chk("load_cnt", retire_count, 32'd31);
    rst_n = 1'b0;
    #1;
    chk("arst_r31", rs1_data, 32'h0);
    chk("arst_r1", rs2_data, 32'h0);
    chk("arst_cnt", retire_count, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_r31", rs1_data, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'h0);
    rs1_addr = 5'd0;
    #1;
    chk("wr5_we", 32'(wb_we), 32'd1);
    chk("wr5_data", wb_data, 32'hDEAD_BEEF);
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    rs1_addr = 5'd5;
    #1;
    chk("rd5", rs1_data, 32'hDEAD_BEEF);
    chk("cnt1", retire_count, 32'd1);
    drive(1'b1, 1'b1, 1'b1, 5'd7, 32'hFFFF_FFFF, 32'h1234_5678);
    rs1_addr = 5'd7;
    rs2_addr = 5'd7;
    #1;
    chk("m2r_data", wb_data, 32'h1234_5678);
    chk("byp_rs1", rs1_data, 32'h1234_5678);
    chk("byp_rs2", rs2_data, 32'h1234_5678);
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    #1;
    chk("rd7", rs1_data, 32'h1234_5678);
    chk("cnt2", retire_count, 32'd2);
    drive(1'b1, 1'b1, 1'b0, 5'd5, 32'h0BAD_F00D, 32'h0);
    rs1_addr = 5'd7;
    rs2_addr = 5'd5;
    #1;
    chk("mix_rs1", rs1_data, 32'h1234_5678);
    chk("mix_rs2", rs2_data, 32'h0BAD_F00D);
    step();
    drive(1'b1, 1'b1, 1'b0, 5'd0, 32'hAAAA_5555, 32'h0);
    rs1_addr = 5'd0;
    #1;
    chk("r0_pre", rs1_data, 32'h0);
    chk("r0_we", 32'(wb_we), 32'd0);
    chk("r0_wbdata", wb_data, 32'hAAAA_5555);
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    #1;
    chk("r0_post", rs1_data, 32'h0);
    chk("cnt4", retire_count, 32'd4);
    drive(1'b1, 1'b1, 1'b0, 5'd9, 32'h0000_0099, 32'h0);
    step();
    drive(1'b0, 1'b1, 1'b0, 5'd9, 32'h0000_5A5A, 32'h0);
    rs1_addr = 5'd9;
    #1;
    chk("bub_we", 32'(wb_we), 32'd0);
    chk("bub_nobyp", rs1_data, 32'h0000_0099);
    step();
    chk("bub_r9", rs1_data, 32'h0000_0099);
    chk("bub_cnt", retire_count, 32'd5);
    drive(1'b1, 1'b0, 1'b0, 5'd9, 32'h0000_7777, 32'h0);
    #1;
    chk("norw_we", 32'(wb_we), 32'd0);
    step();
    chk("norw_r9", rs1_data, 32'h0000_0099);
    chk("norw_cnt", retire_count, 32'd6);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    chk("wrap_pre", retire_count, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    step();
    chk("wrap", retire_count, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 5'd3, 32'h3333_3333, 32'h0);
    rs1_addr = 5'd3;
    rst_n = 1'b0;
    #1;
    chk("rst_hold_byp", rs1_data, 32'h0);
    step();
    chk("rst_hold_nowr", dut.regs[3], 32'h0);
    rst_n = 1'b1;
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    #1;
    chk("rst_first_commit", rs1_data, 32'h3333_3333);
    chk("rst_first_cnt", retire_count, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
